// File: rtl/teclado_pkg.sv
// ---------------------------------------------------------------------------
// teclado_pkg
// Shared definitions for the keypad driver and its consumers.
//   NO_KEY     code presented by the driver while no key is pressed
//   KEY_BKSP   backspace key code
//   KEY_CLR    clear key code
//   estado_t   state encoding of the digit accumulator FSM
//   bin_w()    bit width needed to hold any N-digit decimal value
// ---------------------------------------------------------------------------
package teclado_pkg;

    localparam logic [4:0] NO_KEY   = 5'h1F;
    localparam logic [4:0] KEY_BKSP = 5'h0A;
    localparam logic [4:0] KEY_CLR  = 5'h0B;

    typedef enum logic {
        ESPERA = 1'b0,
        COMMIT = 1'b1
    } estado_t;

    // ceil(log2(10^n)): 10^n - 1 is the largest value, so $clog2(10^n) bits.
    function automatic int bin_w(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// ---------------------------------------------------------------------------
// detector_flanco
// One-bit rising-edge detector. o_rise is high in the cycle where i_d is 1
// and was 0 on the previous clock. RST_VAL sets the remembered level after
// reset; a 1 there suppresses an edge from a level already held high.
//   clk     system clock
//   rst     synchronous active-high reset
//   i_d     level input
//   o_rise  combinational rising-edge pulse
// ---------------------------------------------------------------------------
module detector_flanco #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) r_prev <= RST_VAL;
        else     r_prev <= i_d;
    end

    assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/acumulador_digitos.sv
// ---------------------------------------------------------------------------
// acumulador_digitos
// Collects up to N_DIG decimal key presses from the keypad driver into a
// packed BCD buffer (newest digit in bits [3:0]), with backspace and clear.
// An enter press commits the buffer to valor and pulses valor_valido.
//   clk           system clock
//   rst           synchronous active-high reset
//   digito        key code: 0-9 digit, KEY_BKSP, KEY_CLR, NO_KEY idle
//   enter         enter key level
//   buffer        live BCD digits
//   n_digitos     digits currently held
//   valor         last committed BCD value
//   valor_valido  one-cycle commit strobe
//   desborde      sticky: digit pressed while buffer full
//   valor_bin     binary of the committed value (BIN_OUT_EN only)
// Build option: define BIN_OUT_EN to add valor_bin; the commit then runs an
// N_DIG-cycle MSD-first acc*10+digit conversion before strobing.
// ---------------------------------------------------------------------------
module acumulador_digitos
    import teclado_pkg::KEY_BKSP, teclado_pkg::KEY_CLR, teclado_pkg::estado_t,
           teclado_pkg::ESPERA, teclado_pkg::COMMIT, teclado_pkg::bin_w;
#(
    parameter int         N_DIG  = 4,
    parameter logic [4:0] NO_KEY = 5'h1F
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           digito,
    input  logic                 enter,
    output logic [4*N_DIG-1:0]   buffer,
    output logic [3:0]           n_digitos,
    output logic [4*N_DIG-1:0]   valor,
    output logic                 valor_valido,
`ifdef BIN_OUT_EN
    output logic [bin_w(N_DIG)-1:0] valor_bin,
`endif
    output logic                 desborde
);

    localparam int W = 4 * N_DIG;

    estado_t        r_state, w_next;
    logic [W-1:0]   r_buf, r_valor;
    logic [3:0]     r_n;
    logic           r_vld, r_desb;
    logic [4:0]     r_prev_code;

    logic w_new_enter, w_new_key, w_is_dig, w_is_bksp, w_is_clr;

    // Enter remembers 1 through reset so a held enter does not commit.
    detector_flanco #(.RST_VAL(1'b1)) u_enter (
        .clk    (clk),
        .rst    (rst),
        .i_d    (enter),
        .o_rise (w_new_enter)
    );

    // A key only counts when the previous code was idle; a direct code change
    // (driver rollover) is not a new press.
    assign w_new_key = (digito != NO_KEY) && (r_prev_code == NO_KEY);
    assign w_is_dig  = w_new_key && (digito <= 5'd9);
    assign w_is_bksp = w_new_key && (digito == KEY_BKSP);
    assign w_is_clr  = w_new_key && (digito == KEY_CLR);

`ifdef BIN_OUT_EN
    localparam int BIN_W = bin_w(N_DIG);
    localparam int CNT_W = (N_DIG + 1 > 1) ? $clog2(N_DIG + 1) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_conv;
    logic [BIN_W-1:0] r_acc, r_bin, w_acc_next;
    logic [3:0]       w_dig;
    logic             w_conv_done;

    // Step k (r_cnt = k, 1..N_DIG) consumes digit N_DIG-k, i.e. MSD first.
    assign w_dig       = 4'(r_conv >> (4 * (N_DIG - int'(r_cnt))));
    assign w_acc_next  = r_acc * BIN_W'(10) + BIN_W'(w_dig);
    assign w_conv_done = (r_cnt == CNT_W'(N_DIG));
    assign valor_bin   = r_bin;
`endif

    // ---- FSM ----
    always_ff @(posedge clk) begin
        if (rst) r_state <= ESPERA;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ESPERA: if (w_new_enter) w_next = COMMIT;
`ifdef BIN_OUT_EN
            COMMIT: if (w_conv_done) w_next = ESPERA;
`else
            COMMIT: w_next = ESPERA;
`endif
            default: w_next = ESPERA;
        endcase
    end

    // ---- datapath ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf       <= '0;
            r_n         <= '0;
            r_valor     <= '0;
            r_vld       <= 1'b0;
            r_desb      <= 1'b0;
            r_prev_code <= NO_KEY;
`ifdef BIN_OUT_EN
            r_cnt       <= '0;
            r_conv      <= '0;
            r_acc       <= '0;
            r_bin       <= '0;
`endif
        end else begin
            r_prev_code <= digito;
            r_vld       <= 1'b0;
            case (r_state)
                ESPERA: begin
`ifdef BIN_OUT_EN
                    r_cnt <= '0;
`endif
                    // Enter takes priority; a key in the same cycle is lost.
                    if (!w_new_enter) begin
                        if (w_is_dig) begin
                            if (r_n < 4'(N_DIG)) begin
                                r_buf <= (r_buf << 4) | W'(digito[3:0]);
                                r_n   <= r_n + 4'd1;
                            end else begin
                                r_desb <= 1'b1;
                            end
                        end else if (w_is_bksp) begin
                            if (r_n != 4'd0) begin
                                r_buf <= r_buf >> 4;
                                r_n   <= r_n - 4'd1;
                            end
                        end else if (w_is_clr) begin
                            r_buf  <= '0;
                            r_n    <= '0;
                            r_desb <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
`ifdef BIN_OUT_EN
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == '0) begin
                        // Snapshot, then free the live buffer for display.
                        r_conv <= r_buf;
                        r_acc  <= '0;
                        r_buf  <= '0;
                        r_n    <= '0;
                        r_desb <= 1'b0;
                    end else begin
                        r_acc <= w_acc_next;
                    end
                    if (w_conv_done) begin
                        r_valor <= r_conv;
                        r_bin   <= w_acc_next;
                        r_vld   <= 1'b1;
                    end
`else
                    r_valor <= r_buf;
                    r_vld   <= 1'b1;
                    r_buf   <= '0;
                    r_n     <= '0;
                    r_desb  <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign buffer       = r_buf;
    assign n_digitos    = r_n;
    assign valor        = r_valor;
    assign valor_valido = r_vld;
    assign desborde     = r_desb;

endmodule
